// File: rtl/key_scan_debounce.sv
// Keypad front end: scans a 2-column x 3-row key matrix, synchronises and
// debounces all six keys, and emits a one-cycle pulse on each debounced press.
module key_scan_debounce #(
    parameter int SCAN_DIV = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_row2,
    input  logic       key_row3,
    input  logic       key_row4,
    output logic       key_col1,
    output logic       key_col2,
    output logic [5:0] key_pulse,
    output logic [5:0] key_held
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

    localparam logic [0:0] PH_C1 = 1'b0;
    localparam logic [0:0] PH_C2 = 1'b1;

    logic [2:0]          row_meta_r;
    logic [2:0]          row_sync_r;
    logic [CW-1:0]       cnt_r;
    logic                tick_s;
    logic [0:0]          phase_r;
    logic [0:0]          phase_nxt_s;
    logic [1:0]          col_r;
    logic [1:0]          col_nxt_s;
    logic [5:0]          sample_en_s;
    logic [5:0]          raw_s;
    logic [5:0]          held_r;
    logic [5:0]          held_nxt_s;
    logic [5:0]          pulse_r;
    logic [5:0][DW-1:0]  db_cnt_r;
    logic [5:0][DW-1:0]  db_cnt_nxt_s;

    assign tick_s    = (cnt_r == CNT_MAX);
    // Key bits are interleaved by column, so each synced row feeds two adjacent bits.
    assign raw_s     = {~row_sync_r[2], ~row_sync_r[2],
                        ~row_sync_r[1], ~row_sync_r[1],
                        ~row_sync_r[0], ~row_sync_r[0]};
    assign key_col1  = col_r[1];
    assign key_col2  = col_r[0];
    assign key_held  = held_r;
    assign key_pulse = pulse_r;

    // Two-flop row synchroniser, idle-high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_meta_r <= 3'b111;
            row_sync_r <= 3'b111;
        end else begin
            row_meta_r <= {key_row4, key_row3, key_row2};
            row_sync_r <= row_meta_r;
        end
    end

    // Scan divider: one tick per SCAN_DIV cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Phase sequencing and selection of which keys are sampled this tick.
    always_comb begin
        phase_nxt_s = phase_r;
        col_nxt_s   = col_r;
        sample_en_s = 6'b000000;
        if (tick_s) begin
            case (phase_r)
                PH_C1: begin
                    phase_nxt_s = PH_C2;
                    col_nxt_s   = 2'b10;
                    sample_en_s = 6'b010101;
                end
                PH_C2: begin
                    phase_nxt_s = PH_C1;
                    col_nxt_s   = 2'b01;
                    sample_en_s = 6'b101010;
                end
                default: begin
                    phase_nxt_s = PH_C1;
                    col_nxt_s   = 2'b01;
                    sample_en_s = 6'b000000;
                end
            endcase
        end else begin
            phase_nxt_s = phase_r;
            col_nxt_s   = col_r;
        end
    end

    // Per-key debounce: held flips only after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        held_nxt_s   = held_r;
        db_cnt_nxt_s = db_cnt_r;
        for (int i = 0; i < 6; i++) begin
            if (!sample_en_s[i]) begin
                db_cnt_nxt_s[i] = db_cnt_r[i];
            end else if (raw_s[i] == held_r[i]) begin
                db_cnt_nxt_s[i] = {DW{1'b0}};
            end else if (db_cnt_r[i] == DB_LAST) begin
                held_nxt_s[i]   = ~held_r[i];
                db_cnt_nxt_s[i] = {DW{1'b0}};
            end else begin
                db_cnt_nxt_s[i] = db_cnt_r[i] + DW'(1);
            end
        end
    end

    // State registers; the pulse is set on the same edge that raises key_held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_r  <= PH_C1;
            col_r    <= 2'b01;
            held_r   <= 6'b000000;
            pulse_r  <= 6'b000000;
            db_cnt_r <= '0;
        end else begin
            phase_r  <= phase_nxt_s;
            col_r    <= col_nxt_s;
            held_r   <= held_nxt_s;
            pulse_r  <= held_nxt_s & ~held_r;
            db_cnt_r <= db_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed bench for key_scan_debounce with a behavioural key-matrix model.
module tb_key_scan_debounce;

    logic       clk;
    logic       resetn;
    logic       key_row2;
    logic       key_row3;
    logic       key_row4;
    logic       key_col1;
    logic       key_col2;
    logic [5:0] key_pulse;
    logic [5:0] key_held;
    logic [5:0] pressed;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pulse_cnt [6];
    int pulse_cyc [6];
    logic [5:0] last_vec = 6'b000000;
    int snap [6];

    key_scan_debounce #(.SCAN_DIV(8), .DEBOUNCE(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_row2  (key_row2),
        .key_row3  (key_row3),
        .key_row4  (key_row4),
        .key_col1  (key_col1),
        .key_col2  (key_col2),
        .key_pulse (key_pulse),
        .key_held  (key_held)
    );

    // A row is pulled low when a pressed key sits in the currently driven column.
    assign key_row2 = !((pressed[0] && !key_col1) || (pressed[1] && !key_col2));
    assign key_row3 = !((pressed[2] && !key_col1) || (pressed[3] && !key_col2));
    assign key_row4 = !((pressed[4] && !key_col1) || (pressed[5] && !key_col2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 6; i++) begin
            pulse_cnt[i] = 0;
            pulse_cyc[i] = 0;
        end
    end

    // Pulse monitor, sampled shortly after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (key_pulse != 6'b000000) last_vec = key_pulse;
        for (int i = 0; i < 6; i++) begin
            if (key_pulse[i]) begin
                pulse_cnt[i] = pulse_cnt[i] + 1;
                pulse_cyc[i] = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic take_snap();
        for (int i = 0; i < 6; i++) snap[i] = pulse_cnt[i];
    endtask

    function automatic int total_delta();
        int s = 0;
        for (int i = 0; i < 6; i++) s += pulse_cnt[i] - snap[i];
        return s;
    endfunction

    initial begin
        int lat;
        int d;
        resetn  = 1'b0;
        pressed = 6'b000000;

        // Reset state, mid-run reset and column alternation.
        wait_cycles(3);
        check("rst_col", {30'd0, key_col1, key_col2}, 32'h1);
        check("rst_pulse", {26'd0, key_pulse}, 32'h0);
        check("rst_held", {26'd0, key_held}, 32'h0);
        resetn = 1'b1;
        wait_cycles(8);
        check("col_after8", {30'd0, key_col1, key_col2}, 32'h2);
        resetn = 1'b0;
        #1;
        check("midrst_col", {30'd0, key_col1, key_col2}, 32'h1);
        check("midrst_held", {26'd0, key_held}, 32'h0);
        check("midrst_pulse", {26'd0, key_pulse}, 32'h0);
        wait_cycles(2);
        resetn = 1'b1;
        wait_cycles(7);
        check("col_k7", {30'd0, key_col1, key_col2}, 32'h1);
        wait_cycles(1);
        check("col_k8", {30'd0, key_col1, key_col2}, 32'h2);
        wait_cycles(7);
        check("col_k15", {30'd0, key_col1, key_col2}, 32'h2);
        wait_cycles(1);
        check("col_k16", {30'd0, key_col1, key_col2}, 32'h1);

        // Hold hour_h for 300 cycles, then release.
        take_snap();
        pressed[0] = 1'b1;
        lat = 0;
        while (!key_held[0] && lat < 163) begin
            @(negedge clk);
            lat++;
        end
        check("hh_held_in_time", {31'd0, key_held[0]}, 32'h1);
        wait_cycles(300 - lat);
        check("hh_held_level", {26'd0, key_held}, 32'h1);
        check("hh_pulse_count", pulse_cnt[0] - snap[0], 32'd1);
        check("hh_pulse_total", total_delta(), 32'd1);
        check("hh_pulse_vec", {26'd0, last_vec}, 32'h1);
        pressed[0] = 1'b0;
        lat = 0;
        while (key_held[0] && lat < 163) begin
            @(negedge clk);
            lat++;
        end
        check("hh_release_in_time", {31'd0, key_held[0]}, 32'h0);
        wait_cycles(40);
        check("hh_no_release_pulse", pulse_cnt[0] - snap[0], 32'd1);

        // Bounce min_l: 40-cycle toggles never reach four agreeing samples.
        take_snap();
        for (int t = 0; t < 10; t++) begin
            pressed[3] = ~pressed[3];
            wait_cycles(40);
        end
        wait_cycles(80);
        check("bounce_pulse", pulse_cnt[3] - snap[3], 32'd0);
        check("bounce_held", {26'd0, key_held}, 32'h0);

        // Simultaneous sec_l and min_h.
        take_snap();
        pressed[5] = 1'b1;
        pressed[2] = 1'b1;
        wait_cycles(200);
        check("dual_held", {26'd0, key_held}, 32'h24);
        check("dual_pulse5", pulse_cnt[5] - snap[5], 32'd1);
        check("dual_pulse2", pulse_cnt[2] - snap[2], 32'd1);
        check("dual_total", total_delta(), 32'd2);
        d = pulse_cyc[5] - pulse_cyc[2];
        if (d < 0) d = -d;
        check("dual_sep_nonzero", {31'd0, (d != 0)}, 32'h1);
        check("dual_sep_mult8", d % 8, 32'd0);
        pressed[5] = 1'b0;
        pressed[2] = 1'b0;
        wait_cycles(150);
        check("dual_release", {26'd0, key_held}, 32'h0);

        // Hold hour_l across a reset pulse.
        take_snap();
        pressed[1] = 1'b1;
        wait_cycles(150);
        check("hl_held", {26'd0, key_held}, 32'h2);
        check("hl_pulse1", pulse_cnt[1] - snap[1], 32'd1);
        resetn = 1'b0;
        #1;
        check("hl_rst_held", {26'd0, key_held}, 32'h0);
        wait_cycles(5);
        resetn = 1'b1;
        wait_cycles(200);
        check("hl_redetect_held", {26'd0, key_held}, 32'h2);
        check("hl_pulse2", pulse_cnt[1] - snap[1], 32'd2);
        check("hl_total", total_delta(), 32'd2);
        pressed[1] = 1'b0;
        wait_cycles(150);
        check("hl_release", {26'd0, key_held}, 32'h0);

        // sec_h for only three sample periods.
        take_snap();
        pressed[4] = 1'b1;
        wait_cycles(48);
        check("short_held_during", {31'd0, key_held[4]}, 32'h0);
        pressed[4] = 1'b0;
        wait_cycles(60);
        check("short_held_after", {31'd0, key_held[4]}, 32'h0);
        check("short_pulse", pulse_cnt[4] - snap[4], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
